// File: rtl/rv_soc_apb_master.sv
// rv_soc_apb_master: single-outstanding request/response front end driving APB4 SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout abort is compiled in with `define RV_SOC_APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a request; response pulse appears here
// SETUP  | PSEL high, PENABLE low, one cycle
// ACCESS | PSEL and PENABLE high until PREADY (or timeout abort)
module rv_soc_apb_master #(
  parameter int PADDR_SIZE     = 8,
  parameter int PDATA_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    PRESETn,
  input  logic                    PCLK,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [PADDR_SIZE-1:0]   req_addr_i,
  input  logic [PDATA_SIZE-1:0]   req_wdata_i,
  input  logic [PDATA_SIZE/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  output logic [PDATA_SIZE-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [2:0]              PPROT,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state_q, state_d;
  logic   active_q;
  logic   accept;
  logic   done;
  logic   abort;

  // active_q keeps req_ready_o low while reset is asserted
  assign accept = active_q && (state_q == IDLE) && req_valid_i;
  assign done   = (state_q == ACCESS) && PREADY;

`ifdef RV_SOC_APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  assign abort = (state_q == ACCESS) && !PREADY && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if ((state_q == ACCESS) && !PREADY && !abort) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = active_q;
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        PSEL    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (done || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer fields only change on acceptance, so they hold while PSEL is low
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PPROT  <= '0;
      PSTRB  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PADDR  <= req_addr_i;
      PWRITE <= req_write_i;
      PPROT  <= req_prot_i;
      PSTRB  <= req_write_i ? req_strb_i : '0;
      PWDATA <= req_write_i ? req_wdata_i : '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= done || abort;
      if (done) begin
        rsp_rdata_o <= PWRITE ? '0 : PRDATA;
        rsp_err_o   <= PSLVERR;
      end else if (abort) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rv_soc_apb_master.md
Name: rv_soc_apb_master

Overview:
- APB4 initiator: turns a simple single-outstanding request/response interface into APB4 SETUP/ACCESS transfers.
- Drives the same master-side APB signals that the SoC 32b slave mux and decoder consume.
- Used by debug and DMA-style agents that need to reach PLIC or user APB slaves without an AHB3-Lite bridge.
- One transfer in flight at a time; transfer fields are registered for the whole transfer.

Parameters:
- PADDR_SIZE, 8, APB address width.
- PDATA_SIZE, 32, APB data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase wait cycles before abort; must be >= 1; used only with the optional feature.

Ports:
- PRESETn  in  1  asynchronous active-low reset.
- PCLK  in  1  clock; all logic on rising edge.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high.
- req_write_i  in  1  1=write, 0=read.
- req_addr_i  in  PADDR_SIZE  transfer address.
- req_wdata_i  in  PDATA_SIZE  write data.
- req_strb_i  in  PDATA_SIZE/8  byte strobes.
- req_prot_i  in  3  protection attributes.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata_o  out  PDATA_SIZE  read data; 0 for writes.
- rsp_err_o  out  1  transfer error (PSLVERR or timeout).
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PPROT  out  3  APB protection.
- PWRITE  out  1  APB direction.
- PSTRB  out  PDATA_SIZE/8  APB strobes.
- PADDR  out  PADDR_SIZE  APB address.
- PWDATA  out  PDATA_SIZE  APB write data.
- PRDATA  in  PDATA_SIZE  APB read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (async, PRESETn low): every output is 0 (req_ready_o, rsp_*, PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA). FSM goes to IDLE; the timeout counter clears.
- Reset mid-transfer: PSEL and PENABLE drop immediately (asynchronously). The transfer is lost and no rsp_valid_o is produced.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i: register write, addr, wdata, prot and strb, then go to SETUP.
  - If the request is a read, PSTRB is registered as 0 (APB4 rule).
  - PWDATA is registered as 0 for reads.
- SETUP: PSEL=1, PENABLE=0, req_ready_o=0. Always moves to ACCESS on the next cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS; all APB outputs held stable.
  - PREADY=1: capture PRDATA (reads) or 0 (writes) into rsp_rdata_o, and PSLVERR into rsp_err_o. Go to IDLE; PSEL and PENABLE are 0 on the next cycle.
- Response:
  - rsp_valid_o=1 for exactly the first IDLE cycle after completion.
  - rsp_rdata_o and rsp_err_o hold their values until the next completion.
- Back-to-back requests:
  - A request may be accepted in the same cycle rsp_valid_o is high.
  - Minimum period is 3 cycles per transfer with zero wait states (IDLE, SETUP, ACCESS).
- PADDR, PWRITE, PPROT, PSTRB and PWDATA keep their last values while PSEL=0. They change only on acceptance.
- Request inputs are ignored outside IDLE.

Optional Feature:
- Macro: RV_SOC_APB_MASTER_TIMEOUT_EN.
- Enabled:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to ACCESS.
  - It increments on each ACCESS cycle with PREADY=0.
  - When the counter equals TIMEOUT_CYCLES while PREADY=0, the transfer aborts: next cycle is IDLE with PSEL=PENABLE=0, and rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
  - PREADY=1 in the same cycle as the terminal count takes priority: normal completion.
- Disabled: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Zero-wait write: addr 0x84, data 0xDEADBEEF, strb 0xF → PSEL high 2 cycles, PENABLE in cycle 2, PWRITE=1; rsp_valid_o pulses once with err=0 and rdata=0.
- Read with 2 wait states: addr 0x04, slave returns PRDATA=0x12345678 on the third ACCESS cycle → PSTRB=0 and PADDR stable over all 4 PSEL cycles; rsp_rdata_o=0x12345678.
- Slave error: read with PSLVERR=1 at PREADY → rsp_err_o=1 and rsp_rdata_o=PRDATA value.
- Back-to-back: req_valid_i held high for 3 writes → PSEL is low exactly 1 cycle between transfers; 3 response pulses spaced 3 cycles apart.
- Timeout (macro on, TIMEOUT_CYCLES=4): PREADY tied 0 → abort after 4 wait cycles; rsp_err_o=1, rsp_rdata_o=0. With the macro off, PSEL stays high for 100+ cycles.
- Reset mid-ACCESS: PRESETn low with PSEL=1 → PSEL and PENABLE are 0 in the same cycle; no rsp_valid_o after release; a new request then completes normally.
